// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM encoding, bus widths and FIFO entry layouts.
// Command entries carry {addr, rw, data}; response entries carry {addr, data}.
package i2c_seq_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rsp_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head visible the cycle after the push edge.
// Push is ignored when full and pop when empty; head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells a wrapped-full FIFO from an empty one.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C commands, issues them one at a time to a byte-level master and queues read bytes.
// Five cycles minimum per command; a full response FIFO parks the FSM in RESP until space frees.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int START_TO  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_rw,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  output logic              m_rw,
  output logic              m_enable,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_data_out
);

  localparam int TO_W = $clog2(START_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);

  seq_state_t      state;
  seq_state_t      state_nxt;
  cmd_t            held;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  cmd_t cmd_in;
  cmd_t cmd_head;
  logic cmd_full;
  logic cmd_empty;
  logic cmd_pop;

  rsp_t rsp_in;
  rsp_t rsp_head;
  logic rsp_full;
  logic rsp_empty;
  logic rsp_push;

  assign cmd_in = {cmd_addr, cmd_rw, cmd_data};
  assign rsp_in = {held.addr, m_data_out};

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .full      (cmd_full),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .empty     (cmd_empty)
  );

  sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (rsp_in),
    .full      (rsp_full),
    .pop       (rsp_ready),
    .pop_data  (rsp_head),
    .empty     (rsp_empty)
  );

  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    rsp_push  = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cmd_empty && m_ready) begin
          cmd_pop   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        // The master must acknowledge the start by dropping ready within START_TO cycles.
        if (!m_ready) begin
          state_nxt = ST_WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (m_ready) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (!held.rw) begin
          state_nxt = ST_IDLE;
        end else if (!rsp_full) begin
          rsp_push  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      held   <= '0;
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_pop) held <= cmd_head;
      if (timeout) err <= 1'b1;
      to_cnt <= (state == ST_WAIT_BUSY) ? to_cnt + 1'b1 : '0;
    end
  end

  assign m_enable  = (state == ST_ISSUE);
  assign m_addr    = held.addr;
  assign m_rw      = held.rw;
  assign m_data_in = held.data;

  assign cmd_ready = !cmd_full;
  assign busy      = (state != ST_IDLE) || !cmd_empty;
  assign rsp_valid = !rsp_empty;
  assign rsp_addr  = rsp_head.addr;
  assign rsp_data  = rsp_head.data;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural master/slave and a transaction-level scoreboard.
module tb_i2c_cmd_sequencer;

  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int START_TO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [6:0] rsp_addr;
  logic       busy;
  logic       err;
  logic [6:0] m_addr;
  logic [7:0] m_data_in;
  logic       m_rw;
  logic       m_enable;
  logic       m_ready = 1'b1;
  logic [7:0] m_data_out = '0;

  int checks = 0;
  int errors = 0;

  // Scoreboard: transactions in acceptance order, responses in bus-completion order.
  logic [15:0] exp_txn[$];
  logic [14:0] exp_rsp[$];
  int          pushes = 0;
  int          pops = 0;
  int          pulses = 0;
  int          rsp_pops = 0;
  logic        have_cur = 1'b0;
  logic [15:0] cur_txn = '0;
  logic        prev_en = 1'b0;
  logic        prev_err = 1'b0;
  logic        exp_ready;

  // Master/slave behaviour controls.
  logic        mst_hold = 1'b0;
  logic        mst_stuck = 1'b0;
  logic        mst_reset = 1'b1;
  logic        mst_busy = 1'b0;
  int          drop_dly = 2;
  int          busy_len = 3;
  logic [7:0]  last_wr = '0;

  i2c_cmd_sequencer #(
    .CMD_DEPTH (CMD_DEPTH),
    .RSP_DEPTH (RSP_DEPTH),
    .START_TO  (START_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_rw     (cmd_rw),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .busy       (busy),
    .err        (err),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_rw       (m_rw),
    .m_enable   (m_enable),
    .m_ready    (m_ready),
    .m_data_out (m_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] slave_rd(input logic [6:0] a);
    return {1'b0, a} ^ 8'h76;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Master: drops ready a few cycles after the enable pulse, raises it with the slave byte when done.
  initial begin : master
    int cnt;
    logic [15:0] mtx;
    cnt = 0;
    mtx = '0;
    forever begin
      @(negedge clk);
      if (mst_reset) begin
        m_ready  = 1'b1;
        mst_busy = 1'b0;
      end else if (mst_busy) begin
        cnt++;
        if (cnt == drop_dly) m_ready = 1'b0;
        if (cnt == drop_dly + busy_len) begin
          m_ready = 1'b1;
          if (mtx[8]) begin
            m_data_out = slave_rd(mtx[15:9]);
            exp_rsp.push_back({mtx[15:9], slave_rd(mtx[15:9])});
          end else begin
            last_wr = mtx[7:0];
          end
          mst_busy = 1'b0;
        end
      end else begin
        m_ready = !mst_hold;
        if (m_enable && !mst_stuck) begin
          mtx      = {m_addr, m_rw, m_data_in};
          mst_busy = 1'b1;
          cnt      = 0;
        end
      end
    end
  end

  // Per-cycle compare against the transaction-level model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_txn.delete();
        exp_rsp.delete();
        pushes   = 0;
        pops     = 0;
        have_cur = 1'b0;
        prev_en  = 1'b0;
        prev_err = 1'b0;
      end else begin
        if (m_enable) begin
          chk("enable_single_cycle", 32'(prev_en), 32'd0);
          chk("txn_pending", 32'(exp_txn.size() > 0), 32'd1);
          if (exp_txn.size() > 0) begin
            cur_txn = exp_txn.pop_front();
            chk("txn_fields", 32'({m_addr, m_rw, m_data_in}), 32'(cur_txn));
            have_cur = 1'b1;
          end
          pops++;
          pulses++;
        end else if (have_cur) begin
          chk("held_stable", 32'({m_addr, m_rw, m_data_in}), 32'(cur_txn));
        end
        prev_en = m_enable;

        exp_ready = (pushes - pops) < CMD_DEPTH;
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        if (pushes != pops) chk("busy_queued", 32'(busy), 32'd1);
        if (prev_err) chk("err_sticky", 32'(err), 32'd1);
        prev_err = err;

        if (rsp_valid) begin
          chk("rsp_backed", 32'(exp_rsp.size() > 0), 32'd1);
          if (exp_rsp.size() > 0) begin
            chk("rsp_head", 32'({rsp_addr, rsp_data}), 32'(exp_rsp[0]));
            if (rsp_ready) begin
              void'(exp_rsp.pop_front());
              rsp_pops++;
            end
          end
        end

        if (cmd_valid && exp_ready) begin
          exp_txn.push_back({cmd_addr, cmd_rw, cmd_data});
          pushes++;
        end
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic push_cmd(input logic [6:0] a, input logic rw, input logic [7:0] d);
    int n;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_data  = d;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    checks++;
    if (n == 300) begin
      errors++;
      $display("FAIL push_accept: cmd_ready never high for addr %0h, required acceptance", a);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_enable();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (m_enable) break;
    end
    checks++;
    if (n == 200) begin
      errors++;
      $display("FAIL wait_enable: no m_enable in 200 cycles, required a pulse");
    end
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy && !mst_busy && !(rsp_valid && rsp_ready)) break;
    end
    checks++;
    if (n == 2000) begin
      errors++;
      $display("FAIL wait_idle: still busy after 2000 cycles, required idle");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_m_enable"},  32'(m_enable),  32'd0);
    chk({tag, "_m_addr"},    32'(m_addr),    32'd0);
    chk({tag, "_m_rw"},      32'(m_rw),      32'd0);
    chk({tag, "_m_data_in"}, 32'(m_data_in), 32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_rsp_addr"},  32'(rsp_addr),  32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int rbase;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mst_reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Single write.
    @(posedge clk);
    #1;
    base = pulses;
    push_cmd(7'h2A, 1'b0, 8'hAA);
    wait_enable();
    chk("wr_m_addr", 32'(m_addr), 32'h2A);
    chk("wr_m_rw", 32'(m_rw), 32'd0);
    chk("wr_m_data_in", 32'(m_data_in), 32'hAA);
    wait_idle();
    chk("wr_pulses", 32'(pulses - base), 32'd1);
    chk("wr_slave_byte", 32'(last_wr), 32'hAA);
    chk("wr_no_rsp", 32'(rsp_valid), 32'd0);

    // Single read, response held until rsp_ready.
    rsp_ready = 1'b0;
    push_cmd(7'h2A, 1'b1, 8'h00);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_addr", 32'(rsp_addr), 32'h2A);
    chk("rd_rsp_data", 32'(rsp_data), 32'h5C);
    repeat (10) @(negedge clk);
    chk("rd_rsp_held", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_held_data", 32'(rsp_data), 32'h5C);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rd_rsp_popped", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;

    // Fill the command FIFO while the master is not ready.
    mst_hold = 1'b1;
    base  = pulses;
    rbase = rsp_pops;
    push_cmd(7'h01, 1'b0, 8'h11);
    push_cmd(7'h02, 1'b1, 8'h00);
    push_cmd(7'h03, 1'b0, 8'h33);
    push_cmd(7'h04, 1'b1, 8'h00);
    @(negedge clk);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    chk("full_no_issue", 32'(pulses - base), 32'd0);
    @(posedge clk);
    #1;
    mst_hold = 1'b0;
    wait_idle();
    chk("full_pulses", 32'(pulses - base), 32'd4);
    chk("full_rsp_count", 32'(rsp_pops - rbase), 32'd2);

    // Five reads against a four-entry response FIFO, then a write behind them.
    rsp_ready = 1'b0;
    base  = pulses;
    rbase = rsp_pops;
    for (int i = 0; i < 5; i++) push_cmd(7'(7'h10 + i), 1'b1, 8'h00);
    push_cmd(7'h15, 1'b0, 8'h5A);
    repeat (100) @(negedge clk);
    chk("bp_pulses", 32'(pulses - base), 32'd5);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_no_pops", 32'(rsp_pops - rbase), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle();
    chk("bp_drained", 32'(rsp_pops - rbase), 32'd5);
    chk("bp_pulses_after", 32'(pulses - base), 32'd6);
    chk("bp_last_wr", 32'(last_wr), 32'h5A);

    // Start timeout: master never drops ready.
    mst_stuck = 1'b1;
    base  = pulses;
    rbase = rsp_pops;
    push_cmd(7'h11, 1'b1, 8'h00);
    wait_enable();
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) chk("to_err_before", 32'(err), 32'd0);
      if (k == 17) begin
        chk("to_err_set", 32'(err), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    mst_stuck = 1'b0;
    push_cmd(7'h33, 1'b0, 8'h44);
    wait_idle();
    chk("to_next_issued", 32'(pulses - base), 32'd2);
    chk("to_next_wr", 32'(last_wr), 32'h44);
    chk("to_no_rsp", 32'(rsp_pops - rbase), 32'd0);
    chk("to_err_kept", 32'(err), 32'd1);

    // Reset during WAIT_DONE of a slow read.
    busy_len = 30;
    push_cmd(7'h44, 1'b1, 8'h00);
    wait_enable();
    repeat (6) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mst_reset = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mst_reset = 1'b0;
    busy_len = 3;
    @(negedge clk);
    check_reset_values("midrst");
    repeat (40) @(negedge clk);
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);

    // Normal operation resumes after reset.
    @(posedge clk);
    #1;
    rbase = rsp_pops;
    push_cmd(7'h2A, 1'b1, 8'h00);
    wait_idle();
    chk("post_rst_read", 32'(rsp_pops - rbase), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
